gen_reg_file: RTL and testbench

- Parametrised successor to the fixed 8-bit, 4+4-register file: NUM_REGS registers of WIDTH bits, each with the standard funsel ops (clear/load/dec/inc).
- Adds lane-masked partial loads (generalising the IR low/high byte load), a selectable wrap or saturate mode, and per-register sticky overflow flags and zero flags.
- Sits between the data-path muxes and the ALU/memory-address paths. Serves as general register file, address register file or wide IR, depending on parameters.

---
 rtl/gen_reg_file.sv | 112 +++++++++++
 tb/tb_gen_reg_file.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_reg_file.sv
// Parametrised register file: NUM_REGS x WIDTH registers with clear/load/dec/inc,
// lane-masked loads, wrap or saturate arithmetic, sticky overflow and zero flags.
module gen_reg_file #(
  parameter int WIDTH    = 16,
  parameter int LANE     = 8,
  parameter int NUM_REGS = 8,
  parameter int SAT      = 0,
  localparam int NL      = WIDTH / LANE,
  localparam int SW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          funsel,
  input  logic [NUM_REGS-1:0] rsel,
  input  logic [WIDTH-1:0]    load,
  input  logic [NL-1:0]       lane_en,
  input  logic [SW-1:0]       o1sel,
  input  logic [SW-1:0]       o2sel,
  input  logic [NUM_REGS-1:0] flag_clr,
  output logic [WIDTH-1:0]    o1,
  output logic [WIDTH-1:0]    o2,
  output logic [NUM_REGS-1:0] zero,
  output logic [NUM_REGS-1:0] ovf
);

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;

  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [WIDTH-1:0] value_reg;
      logic [WIDTH-1:0] value_next;
      logic [WIDTH-1:0] load_merged;
      logic             ovf_reg;
      logic             ovf_next;
      logic             ovf_set;
      logic             ovf_kill;
      logic             is_zero;
      logic             is_full;

      // Unselected lanes keep their current contents on a load.
      for (gk = 0; gk < NL; gk++) begin : g_lane
        assign load_merged[gk*LANE +: LANE] =
          lane_en[gk] ? load[gk*LANE +: LANE] : value_reg[gk*LANE +: LANE];
      end

      assign is_zero = (value_reg == ALL_ZERO);
      assign is_full = (value_reg == ALL_ONES);

      always_comb begin
        value_next = value_reg;
        ovf_set    = 1'b0;
        ovf_kill   = 1'b0;
        if (rsel[gi]) begin
          case (funsel)
            OP_CLR: begin
              value_next = ALL_ZERO;
              ovf_kill   = 1'b1;
            end
            OP_LD: value_next = load_merged;
            OP_DEC: begin
              if (is_zero) begin
                ovf_set    = 1'b1;
                value_next = (SAT != 0) ? ALL_ZERO : ALL_ONES;
              end else begin
                value_next = value_reg - ONE;
              end
            end
            OP_INC: begin
              if (is_full) begin
                ovf_set    = 1'b1;
                value_next = (SAT != 0) ? ALL_ONES : ALL_ZERO;
              end else begin
                value_next = value_reg + ONE;
              end
            end
            default: value_next = value_reg;
          endcase
        end
        // A new wrap/saturate event beats a same-edge flag_clr.
        ovf_next = ovf_set | (ovf_reg & ~flag_clr[gi] & ~ovf_kill);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg <= ALL_ZERO;
          ovf_reg   <= 1'b0;
        end else begin
          value_reg <= value_next;
          ovf_reg   <= ovf_next;
        end
      end

      assign regs[gi] = value_reg;
      assign zero[gi] = is_zero;
      assign ovf[gi]  = ovf_reg;
    end
  endgenerate

  assign o1 = regs[o1sel];
  assign o2 = regs[o2sel];

endmodule

// File: tb/tb_gen_reg_file.sv
// Scoreboard bench for gen_reg_file: a wrap-mode and a saturate-mode instance share
// stimulus and are checked against a behavioural model of both.
module tb_gen_reg_file;

  logic        clk;
  logic        rst_n;
  logic [1:0]  funsel;
  logic [7:0]  rsel;
  logic [15:0] load;
  logic [1:0]  lane_en;
  logic [2:0]  o1sel;
  logic [2:0]  o2sel;
  logic [7:0]  flag_clr;

  logic [15:0] o1_w, o2_w, o1_s, o2_s;
  logic [7:0]  zero_w, ovf_w, zero_s, ovf_s;

  gen_reg_file #(.WIDTH(16), .LANE(8), .NUM_REGS(8), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .funsel(funsel), .rsel(rsel), .load(load),
    .lane_en(lane_en), .o1sel(o1sel), .o2sel(o2sel), .flag_clr(flag_clr),
    .o1(o1_w), .o2(o2_w), .zero(zero_w), .ovf(ovf_w)
  );

  gen_reg_file #(.WIDTH(16), .LANE(8), .NUM_REGS(8), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .funsel(funsel), .rsel(rsel), .load(load),
    .lane_en(lane_en), .o1sel(o1sel), .o2sel(o2sel), .flag_clr(flag_clr),
    .o1(o1_s), .o2(o2_s), .zero(zero_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          watch;
    logic [15:0] v_w;
    logic [15:0] v_s;
    logic [7:0]  z_w;
    logic [7:0]  z_s;
    logic [7:0]  f_w;
    logic [7:0]  f_s;
  } exp_t;

  exp_t sb[$];

  // Model state: index 0 = wrap instance, 1 = saturate instance.
  logic [15:0] mem  [2][8];
  logic [7:0]  mflag[2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] zvec(input int m);
    logic [7:0] z;
    for (int i = 0; i < 8; i++) z[i] = (mem[m][i] == 16'h0000);
    return z;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) mem[m][i] = 16'h0000;
      mflag[m] = 8'h00;
    end
  endtask

  task automatic model_apply(input logic [1:0] f, input logic [7:0] rs, input logic [15:0] ld,
                             input logic [1:0] le, input logic [7:0] fc);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) begin
        logic nf;
        nf = mflag[m][i] & ~fc[i];
        if (rs[i]) begin
          case (f)
            2'b00: begin mem[m][i] = 16'h0000; nf = 1'b0; end
            2'b01: begin
              if (le[0]) mem[m][i][7:0]  = ld[7:0];
              if (le[1]) mem[m][i][15:8] = ld[15:8];
            end
            2'b10: begin
              if (mem[m][i] == 16'h0000) begin
                nf = 1'b1;
                mem[m][i] = (m == 1) ? 16'h0000 : 16'hFFFF;
              end else mem[m][i] = mem[m][i] - 16'h0001;
            end
            default: begin
              if (mem[m][i] == 16'hFFFF) begin
                nf = 1'b1;
                mem[m][i] = (m == 1) ? 16'hFFFF : 16'h0000;
              end else mem[m][i] = mem[m][i] + 16'h0001;
            end
          endcase
        end
        mflag[m][i] = nf;
      end
    end
  endtask

  // One transaction: drive at negedge, push expectation, compare after the edge.
  task automatic op(input string tag, input logic [1:0] f, input logic [7:0] rs,
                    input logic [15:0] ld, input logic [1:0] le, input logic [7:0] fc,
                    input int w);
    exp_t e;
    @(negedge clk);
    funsel = f; rsel = rs; load = ld; lane_en = le; flag_clr = fc;
    model_apply(f, rs, ld, le, fc);
    e.tag = tag; e.watch = w;
    e.v_w = mem[0][w]; e.v_s = mem[1][w];
    e.z_w = zvec(0);   e.z_s = zvec(1);
    e.f_w = mflag[0];  e.f_s = mflag[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
    rsel = 8'h00; flag_clr = 8'h00;
    o1sel = 3'(w); o2sel = 3'(w);
    #1;
    e = sb.pop_front();
    check({e.tag, ".o1_w"}, 32'(o1_w), 32'(e.v_w));
    check({e.tag, ".o2_w"}, 32'(o2_w), 32'(e.v_w));
    check({e.tag, ".o1_s"}, 32'(o1_s), 32'(e.v_s));
    check({e.tag, ".zero_w"}, 32'(zero_w), 32'(e.z_w));
    check({e.tag, ".zero_s"}, 32'(zero_s), 32'(e.z_s));
    check({e.tag, ".ovf_w"}, 32'(ovf_w), 32'(e.f_w));
    check({e.tag, ".ovf_s"}, 32'(ovf_s), 32'(e.f_s));
    $display("op %-10s f=%b rsel=%h load=%h le=%b fc=%h R%0d: wrap=%h sat=%h ovf_w=%h ovf_s=%h",
             e.tag, f, rs, ld, le, fc, w, o1_w, o1_s, ovf_w, ovf_s);
  endtask

  task automatic verify_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      o1sel = 3'(i);
      #1;
      check($sformatf("%s.R%0d_w", tag, i), 32'(o1_w), 32'(mem[0][i]));
      check($sformatf("%s.R%0d_s", tag, i), 32'(o1_s), 32'(mem[1][i]));
    end
    $display("verify %s done", tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".o1_w"}, 32'(o1_w), 32'h0);
    check({tag, ".o2_w"}, 32'(o2_w), 32'h0);
    check({tag, ".o1_s"}, 32'(o1_s), 32'h0);
    check({tag, ".zero_w"}, 32'(zero_w), 32'hFF);
    check({tag, ".zero_s"}, 32'(zero_s), 32'hFF);
    check({tag, ".ovf_w"}, 32'(ovf_w), 32'h00);
    check({tag, ".ovf_s"}, 32'(ovf_s), 32'h00);
  endtask

  initial begin
    rst_n = 1'b0; funsel = 2'b00; rsel = 8'h00; load = 16'h0000; lane_en = 2'b00;
    o1sel = 3'd0; o2sel = 3'd0; flag_clr = 8'h00;
    model_reset();
    #12;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Lane-masked loads into R2
    op("lane_lo", 2'b01, 8'h04, 16'hABCD, 2'b01, 8'h00, 2);
    op("lane_hi", 2'b01, 8'h04, 16'h1234, 2'b10, 8'h00, 2);
    op("lane_none", 2'b01, 8'h04, 16'h5555, 2'b00, 8'h00, 2);

    // Wrap / saturate at the top on R3
    op("r3_load", 2'b01, 8'h08, 16'hFFFF, 2'b11, 8'h00, 3);
    op("r3_inc", 2'b11, 8'h08, 16'h0000, 2'b00, 8'h00, 3);
    op("r3_dec", 2'b10, 8'h08, 16'h0000, 2'b00, 8'h00, 3);
    op("r3_fclr", 2'b01, 8'h00, 16'h0000, 2'b00, 8'h08, 3);

    // Underflow at zero on R1, then overflow
    op("r1_dec0", 2'b10, 8'h02, 16'h0000, 2'b00, 8'h00, 1);
    op("r1_load", 2'b01, 8'h02, 16'hFFFF, 2'b11, 8'h00, 1);
    op("r1_inc", 2'b11, 8'h02, 16'h0000, 2'b00, 8'h00, 1);
    op("r1_clr", 2'b00, 8'h02, 16'h0000, 2'b00, 8'h00, 1);

    // Set beats same-edge flag_clr on R0
    op("r0_load", 2'b01, 8'h01, 16'hFFFF, 2'b11, 8'h00, 0);
    op("r0_incfc", 2'b11, 8'h01, 16'h0000, 2'b00, 8'h01, 0);

    // Fill every register, then clear R0 and R7 together
    for (int i = 0; i < 8; i++)
      op($sformatf("fill%0d", i), 2'b01, 8'(1 << i), 16'(16'h1010 * (i + 1) + i), 2'b11, 8'h00, i);
    op("multi_clr", 2'b00, 8'h81, 16'h0000, 2'b00, 8'h00, 7);
    verify_all("after_mclr");

    // Read ports
    op("r5_load", 2'b01, 8'h20, 16'h00AA, 2'b11, 8'h00, 5);
    op("r6_load", 2'b01, 8'h40, 16'h0055, 2'b11, 8'h00, 6);
    @(negedge clk);
    o1sel = 3'd5; o2sel = 3'd6;
    #1;
    check("rp.o1", 32'(o1_w), 32'h00AA);
    check("rp.o2", 32'(o2_w), 32'h0055);
    o1sel = 3'd6;
    #1;
    check("rp.same_o1", 32'(o1_w), 32'h0055);
    check("rp.same_o2", 32'(o2_w), 32'h0055);
    @(negedge clk);
    funsel = 2'b01; rsel = 8'h40; load = 16'h0077; lane_en = 2'b11;
    #1;
    check("rp.pre_edge", 32'(o2_w), 32'h0055);
    model_apply(2'b01, 8'h40, 16'h0077, 2'b11, 8'h00);
    @(posedge clk);
    #1;
    rsel = 8'h00;
    check("rp.post_edge_o1", 32'(o1_w), 32'h0077);
    check("rp.post_edge_o2", 32'(o2_w), 32'h0077);
    $display("read-port transaction R6 old=0055 new=%h", o2_w);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] fc;
      fc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      op($sformatf("rnd%0d", n), 2'($urandom), 8'($urandom), 16'($urandom),
         2'($urandom), fc, int'($urandom_range(0, 7)));
    end
    // Force some extremes so wrap/saturate paths see random traffic too
    op("rnd_full", 2'b01, 8'hF0, 16'hFFFF, 2'b11, 8'h00, 4);
    op("rnd_inc", 2'b11, 8'hFF, 16'h0000, 2'b00, 8'h0F, 4);
    op("rnd_dec", 2'b10, 8'h3C, 16'h0000, 2'b00, 8'h00, 5);
    verify_all("after_rnd");

    // Asynchronous reset mid-cycle while registers hold data
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst", 2'b11, 8'h01, 16'h0000, 2'b00, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
